ahbl_apb4_bridge_mslot: RTL and testbench

//  AHB-Lite slave to APB4 master bridge with NUM_SLOTS decoded PSEL lines.

---
 rtl/ahbl_apb_pkg.sv | 58 +++++
 rtl/apb_access_timer.sv | 43 ++++
 rtl/ahbl_apb4_bridge_mslot.sv | 216 +++++++++++++++++++++
 tb/tb_ahbl_apb4_bridge_mslot.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_apb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ahbl_apb_pkg                                               |
// | Description : Shared AHB-Lite / APB4 encodings, bridge FSM state type    |
// |               and small helper functions for the AHB-to-APB bridge.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ahbl_apb_pkg;

  // AHB-Lite transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB-Lite response encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // AHB-Lite transfer sizes supported by the bridge
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } bridge_state_t;

  // Timeout counter width: just wide enough to hold the limit, clamped to 8..16.
  function automatic int timer_width(input int cycles);
    int w;
    w = 8;
    for (int i = 8; i < 16; i++) begin
      if ((cycles >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // APB4 write strobes for a naturally aligned byte/half/word transfer.
  function automatic logic [3:0] strobe_for(input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_access_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : apb_access_timer                                           |
// | Description : Saturating ACCESS-phase cycle counter. Cleared by i_load,  |
// |               counts while i_enable, flags o_expire on the last allowed  |
// |               ACCESS cycle.                                              |
// | Ports       : clk, rst (async, active-high)                              |
// |               i_load   - clear the counter (SETUP cycle)                 |
// |               i_enable - count this cycle (ACCESS cycle)                 |
// |               o_expire - counter reached TIMEOUT_CYCLES-1 while enabled  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module apb_access_timer
  import ahbl_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expire
);

  localparam int             C_WIDTH = timer_width(TIMEOUT_CYCLES);
  localparam logic [C_WIDTH-1:0] C_LAST = C_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [C_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + C_WIDTH'(1);
    end
  end

  assign o_expire = i_enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ahbl_apb4_bridge_mslot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ahbl_apb4_bridge_mslot                                     |
// | Description : AHB-Lite slave to APB4 master bridge with NUM_SLOTS        |
// |               one-hot PSEL lines, PSTRB/PPROT generation, optional       |
// |               ACCESS timeout and ERROR response for unmapped slots or    |
// |               unsupported sizes.                                         |
// | Ports       : HCLK, HRESET (async, active-high)                          |
// |               AHB side : HSEL HADDR HTRANS HWRITE HSIZE HPROT HWDATA     |
// |                          HREADYIN -> HREADYOUT HRESP HRDATA              |
// |               APB side : PSEL PADDR PENABLE PWRITE PWDATA PSTRB PPROT    |
// |                          <- PRDATA PREADY PSLVERR                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ahbl_apb4_bridge_mslot
  import ahbl_apb_pkg::*;
#(
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_LSB       = 24,
  parameter int PADDR_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [3:0]             HPROT,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADYIN,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  output logic [NUM_SLOTS-1:0]   PSEL,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic [3:0]             PSTRB,
  output logic [2:0]             PPROT,
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  bridge_state_t          r_state;
  bridge_state_t          w_next_state;

  logic [3:0]             r_slot;
  logic [PADDR_WIDTH-1:0] r_paddr;
  logic                   r_pwrite;
  logic [3:0]             r_pstrb;
  logic [2:0]             r_pprot;
  logic [31:0]            r_pwdata;
  logic [31:0]            r_hrdata;

  logic                   w_accept;
  logic [3:0]             w_slot;
  logic                   w_slot_bad;
  logic                   w_size_bad;
  logic                   w_decode_err;
  logic                   w_expire;
  logic                   w_hreadyout;
  logic                   w_hresp;
  logic                   w_penable;
  logic                   w_sel_active;
  logic [NUM_SLOTS-1:0]   w_psel;
  logic                   w_unused;

  // Address-phase decode. Only NONSEQ/SEQ start a transfer; IDLE/BUSY get the
  // zero-wait OKAY that IDLE already presents.
  assign w_accept     = HSEL && HREADYIN && (r_state == IDLE) &&
                        (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);
  assign w_slot       = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign w_slot_bad   = ({1'b0, w_slot} >= 5'(NUM_SLOTS));
  assign w_size_bad   = (HSIZE > HSIZE_WORD);
  assign w_decode_err = w_slot_bad || w_size_bad;

  // Address bits outside the slot/PADDR fields and the cacheable/bufferable
  // HPROT bits have no APB meaning.
  assign w_unused = ^{HPROT[3:2], HADDR};

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      apb_access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk      (HCLK),
        .rst      (HRESET),
        .i_load   (r_state == SETUP),
        .i_enable (r_state == ACCESS),
        .o_expire (w_expire)
      );
    end else begin : g_no_timer
      assign w_expire = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hreadyout  = 1'b0;
    w_hresp      = HRESP_OKAY;
    w_penable    = 1'b0;
    w_sel_active = 1'b0;
    case (r_state)
      IDLE: begin
        w_hreadyout = 1'b1;
        if (w_accept) begin
          if (w_decode_err) begin
            w_next_state = ERR1;
          end else if (HWRITE) begin
            w_next_state = WDATA;
          end else begin
            w_next_state = SETUP;
          end
        end
      end
      WDATA: begin
        w_next_state = SETUP;
      end
      SETUP: begin
        w_sel_active = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        w_sel_active = 1'b1;
        w_penable    = 1'b1;
        // PSLVERR only counts when qualified by PREADY.
        if (PREADY) begin
          w_next_state = PSLVERR ? ERR1 : IDLE;
        end else if (w_expire) begin
          w_next_state = ERR1;
        end
      end
      ERR1: begin
        w_hresp      = HRESP_ERROR;
        w_next_state = ERR2;
      end
      ERR2: begin
        w_hreadyout  = 1'b1;
        w_hresp      = HRESP_ERROR;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    w_psel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_sel_active && (r_slot == 4'(i))) w_psel[i] = 1'b1;
    end
  end

  // -------------------------------------------------- APB request fields ---
  // Captured on a mapped accept and held until the next mapped accept, so
  // they are stable through SETUP/ACCESS and after completion.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_slot   <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= '0;
      r_pprot  <= '0;
    end else if (w_accept && !w_decode_err) begin
      r_slot   <= w_slot;
      r_paddr  <= HADDR[PADDR_WIDTH-1:0];
      r_pwrite <= HWRITE;
      r_pstrb  <= HWRITE ? strobe_for(HSIZE, HADDR[1:0]) : 4'b0000;
      r_pprot  <= {~HPROT[0], 1'b1, HPROT[1]};
    end
  end

  // HWDATA belongs to the AHB data phase, which is the WDATA cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pwdata <= '0;
    end else if (r_state == WDATA) begin
      r_pwdata <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hrdata <= '0;
    end else if ((r_state == ACCESS) && PREADY && !PSLVERR && !r_pwrite) begin
      r_hrdata <= PRDATA;
    end
  end

  assign HREADYOUT = w_hreadyout;
  assign HRESP     = w_hresp;
  assign HRDATA    = r_hrdata;
  assign PSEL      = w_psel;
  assign PENABLE   = w_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_apb4_bridge_mslot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ahbl_apb4_bridge_mslot                                  |
// | Description : Self-checking bench for ahbl_apb4_bridge_mslot. Two        |
// |               instances: A (16 slots, no timeout) and B (4 slots,        |
// |               8-cycle timeout). Expected behaviour comes from a          |
// |               transaction-level model of the bridge rules.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ahbl_apb4_bridge_mslot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel;
  logic        use_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr_val;
  logic        pslverr;
  logic        hsel_a;
  logic        hsel_b;

  // The slave raises PSLVERR whenever PREADY is low; the bridge must ignore it.
  assign pslverr = pready ? pslverr_val : 1'b1;
  assign hsel_a  = hsel && !use_b;
  assign hsel_b  = hsel && use_b;

  logic        a_hreadyout, a_hresp, a_penable, a_pwrite;
  logic [31:0] a_hrdata, a_pwdata;
  logic [15:0] a_psel;
  logic [23:0] a_paddr;
  logic [3:0]  a_pstrb;
  logic [2:0]  a_pprot;

  logic        b_hreadyout, b_hresp, b_penable, b_pwrite;
  logic [31:0] b_hrdata, b_pwdata;
  logic [3:0]  b_psel;
  logic [23:0] b_paddr;
  logic [3:0]  b_pstrb;
  logic [2:0]  b_pprot;

  ahbl_apb4_bridge_mslot #(
    .NUM_SLOTS(16), .SLOT_LSB(24), .PADDR_WIDTH(24), .TIMEOUT_CYCLES(0)
  ) dut_a (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HWDATA(hwdata),
    .HREADYIN(hreadyin), .HREADYOUT(a_hreadyout), .HRESP(a_hresp),
    .HRDATA(a_hrdata), .PSEL(a_psel), .PADDR(a_paddr), .PENABLE(a_penable),
    .PWRITE(a_pwrite), .PWDATA(a_pwdata), .PSTRB(a_pstrb), .PPROT(a_pprot),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  ahbl_apb4_bridge_mslot #(
    .NUM_SLOTS(4), .SLOT_LSB(24), .PADDR_WIDTH(24), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HWDATA(hwdata),
    .HREADYIN(hreadyin), .HREADYOUT(b_hreadyout), .HRESP(b_hresp),
    .HRDATA(b_hrdata), .PSEL(b_psel), .PADDR(b_paddr), .PENABLE(b_penable),
    .PWRITE(b_pwrite), .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PPROT(b_pprot),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  // Outputs of whichever instance is under test.
  logic        w_ready, w_hresp, w_penable, w_pwrite;
  logic [31:0] w_hrdata, w_pwdata;
  logic [15:0] w_psel;
  logic [23:0] w_paddr;
  logic [3:0]  w_pstrb;
  logic [2:0]  w_pprot;

  assign w_ready   = use_b ? b_hreadyout : a_hreadyout;
  assign w_hresp   = use_b ? b_hresp     : a_hresp;
  assign w_penable = use_b ? b_penable   : a_penable;
  assign w_pwrite  = use_b ? b_pwrite    : a_pwrite;
  assign w_hrdata  = use_b ? b_hrdata    : a_hrdata;
  assign w_pwdata  = use_b ? b_pwdata    : a_pwdata;
  assign w_psel    = use_b ? {12'd0, b_psel} : a_psel;
  assign w_paddr   = use_b ? b_paddr     : a_paddr;
  assign w_pstrb   = use_b ? b_pstrb     : a_pstrb;
  assign w_pprot   = use_b ? b_pprot     : a_pprot;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rd_a = 32'd0;
  logic [31:0] exp_rd_b = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete AHB transfer plus APB slave behaviour, checked against the
  // transaction model. Starts in a cycle where the bridge is ready; returns in
  // a cycle where it is ready again (back-to-back capable).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [3:0] prot, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int wait_n, input logic serr);
    int          ns, tmo, slot, acc, lat, nbytes, a_lo, base, k, n_acc, n_setup;
    bit          derr, tout, err, done;
    logic [3:0]  strb;
    logic [15:0] c_psel;
    logic [23:0] c_paddr;
    logic [31:0] c_pwdata, exp_rd, end_rdata;
    logic [3:0]  c_pstrb;
    logic [2:0]  c_pprot;
    logic        c_pwrite, prev_resp, end_resp, end_psel_any, end_pen;

    // ---- model: what the bridge must do with this transfer ----
    ns     = use_b ? 4 : 16;
    tmo    = use_b ? 8 : 0;
    slot   = int'(addr[27:24]);
    derr   = (slot >= ns) || (size > 3'd2);
    tout   = !derr && (tmo > 0) && (wait_n >= tmo);
    err    = derr || tout || serr;
    acc    = derr ? 0 : (tout ? tmo : wait_n + 1);
    lat    = derr ? 2 : (int'(wr) + 2 + acc + int'(err));
    strb   = 4'b0000;
    if (wr && !derr) begin
      nbytes = 1 << size;
      a_lo   = int'(addr[1:0]);
      base   = a_lo - (a_lo % nbytes);
      for (int i = 0; i < 4; i++)
        if (i >= base && i < base + nbytes) strb[i] = 1'b1;
    end
    if (!err && !wr) begin
      if (use_b) exp_rd_b = rdata; else exp_rd_a = rdata;
    end
    exp_rd = use_b ? exp_rd_b : exp_rd_a;

    // ---- address phase ----
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    hprot = prot; hwdata = ~wdata; prdata = rdata; pslverr_val = serr; pready = 1'b0;
    @(posedge clk); #1;
    // ---- data phase ----
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwdata = wdata;
    k = 0; done = 0; n_acc = 0; n_setup = 0; c_psel = '0; c_paddr = '0;
    c_pwdata = '0; c_pstrb = '0; c_pprot = '0; c_pwrite = 1'b0; prev_resp = 1'b0;
    end_resp = 1'b0; end_rdata = '0; end_psel_any = 1'b0; end_pen = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (w_penable) begin
        n_acc++;
        pready = (n_acc > wait_n);
      end else begin
        pready = 1'b0;
      end
      if ((w_psel != 16'd0) && !w_penable) begin
        n_setup++;
        c_psel = w_psel; c_paddr = w_paddr; c_pwrite = w_pwrite;
        c_pstrb = w_pstrb; c_pprot = w_pprot; c_pwdata = w_pwdata;
      end
      if (w_ready) begin
        done = 1; end_resp = w_hresp; end_rdata = w_hrdata;
        end_psel_any = (w_psel != 16'd0); end_pen = w_penable;
      end else begin
        prev_resp = w_hresp;
      end
    end
    pready = 1'b0;

    check("xfer_done", 32'(done), 32'd1);
    check("latency", 32'(k), 32'(lat));
    check("hresp_end", 32'(end_resp), 32'(err));
    if (err) check("hresp_err1", 32'(prev_resp), 32'd1);
    check("psel", 32'(c_psel), derr ? 32'd0 : (32'd1 << slot));
    check("setup_cycles", 32'(n_setup), derr ? 32'd0 : 32'd1);
    check("access_cycles", 32'(n_acc), 32'(acc));
    if (!derr) begin
      check("paddr", 32'(c_paddr), {8'd0, addr[23:0]});
      check("pwrite", 32'(c_pwrite), 32'(wr));
      check("pstrb", 32'(c_pstrb), 32'(strb));
      check("pprot", 32'(c_pprot), 32'({~prot[0], 1'b1, prot[1]}));
      if (wr) check("pwdata", c_pwdata, wdata);
    end
    check("hrdata", end_rdata, exp_rd);
    check("apb_idle_after", 32'({end_psel_any, end_pen}), 32'd0);
    // A master drives IDLE during the second error cycle.
    if (err) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hreadyout"}, 32'(a_hreadyout), 32'd1);
    check({tag, "_hresp"},     32'(a_hresp),     32'd0);
    check({tag, "_hrdata"},    a_hrdata,         32'd0);
    check({tag, "_psel"},      32'(a_psel),      32'd0);
    check({tag, "_penable"},   32'(a_penable),   32'd0);
    check({tag, "_pwrite"},    32'(a_pwrite),    32'd0);
    check({tag, "_paddr"},     32'(a_paddr),     32'd0);
    check({tag, "_pwdata"},    a_pwdata,         32'd0);
    check({tag, "_pstrb"},     32'(a_pstrb),     32'd0);
    check({tag, "_pprot"},     32'(a_pprot),     32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; hsel = 1'b0; use_b = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hprot = 4'd0; hwdata = '0; hreadyin = 1'b1; prdata = '0;
    pready = 1'b0; pslverr_val = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // BUSY and IDLE transfers: zero-wait OKAY, no APB activity.
    hsel = 1'b1; htrans = 2'b01;
    @(negedge clk);
    check("busy_ready", 32'(a_hreadyout), 32'd1);
    check("busy_hresp", 32'(a_hresp), 32'd0);
    check("busy_psel", 32'(a_psel), 32'd0);
    htrans = 2'b10; hreadyin = 1'b0;
    @(negedge clk);
    check("nohready_psel", 32'(a_psel), 32'd0);
    check("nohready_ready", 32'(a_hreadyout), 32'd1);
    hreadyin = 1'b1; hsel = 1'b0; htrans = 2'b00;

    // Directed transfers on instance A (16 slots, no timeout).
    xfer(32'h0300_0010, 1'b0, 3'd2, 4'b0011, 32'h0, 32'hA5A5_1234, 0, 1'b0);
    xfer(32'h0100_0002, 1'b1, 3'd0, 4'b0001, 32'h00CC_0000, 32'h0, 0, 1'b0);
    xfer(32'h0500_0104, 1'b0, 3'd2, 4'b0000, 32'h0, 32'h1357_9BDF, 5, 1'b0);
    xfer(32'h0200_0020, 1'b0, 3'd2, 4'b0010, 32'h0, 32'hFFFF_0000, 0, 1'b1);
    xfer(32'h0F00_00FC, 1'b1, 3'd2, 4'b0011, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
    xfer(32'h0400_0002, 1'b1, 3'd1, 4'b0001, 32'h1234_0000, 32'h0, 0, 1'b0);
    xfer(32'h0400_0000, 1'b1, 3'd3, 4'b0001, 32'h1111_2222, 32'h0, 0, 1'b0);
    xfer(32'h0600_0008, 1'b1, 3'd2, 4'b0000, 32'h5555_AAAA, 32'h0, 2, 1'b1);

    // Instance B: 4 slots, 8-cycle timeout.
    use_b = 1'b1;
    xfer(32'h0700_0000, 1'b0, 3'd2, 4'b0000, 32'h0, 32'h7777_7777, 0, 1'b0);
    xfer(32'h0100_0010, 1'b0, 3'd2, 4'b0000, 32'h0, 32'h0BAD_0BAD, 20, 1'b0);
    xfer(32'h0200_0030, 1'b0, 3'd2, 4'b0001, 32'h0, 32'h0600_D00D, 7, 1'b0);
    xfer(32'h0300_0001, 1'b1, 3'd0, 4'b0010, 32'h0000_BB00, 32'h0, 0, 1'b0);

    // Reset in the middle of an ACCESS phase on instance A.
    use_b = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0200_0040; hwrite = 1'b0; hsize = 3'd2;
    hprot = 4'b0011; pready = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    k = 0;
    while (!a_penable && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rst_reached_access", 32'(a_penable), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    exp_rd_a = 32'd0; exp_rd_b = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    xfer(32'h0800_0100, 1'b0, 3'd2, 4'b0001, 32'h0, 32'h2468_ACE0, 0, 1'b0);
    xfer(32'h0900_0200, 1'b0, 3'd2, 4'b0000, 32'h0, 32'h1122_3344, 0, 1'b0);

    // Randomised transfers on both instances.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  slot;
      logic [31:0] addr;
      int          wt;
      use_b = n[0];
      slot  = use_b ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      addr  = {4'h0, slot, 24'($urandom)};
      wt    = ($urandom_range(0, 7) == 0) ? (use_b ? 12 : 6) : $urandom_range(0, 3);
      xfer(addr, 1'($urandom), 3'($urandom_range(0, 3)), 4'($urandom),
           $urandom, $urandom, wt, ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
